// File: rtl/crc32_frame_ctrl.sv
// Frame CRC-32 sequencer: seeds, folds words/tail bytes, reports CRC, residue flag, byte count.
// Latency: result valid 1 cycle after a full/empty last word, 1+n cycles after an n-byte tail.
// Backpressure: s_ready_o drops during tail bytes and while a result waits for crc_ready_i.

// Combinational reflected CRC-32 step over one 32-bit word, byte 0 (bits[7:0]) first.
module crc32_word_core (
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);
  localparam logic [31:0] POLY = 32'hEDB88320;

  logic [31:0] acc;

  // Fold all 32 input bits into the register, one right shift per bit.
  always_comb begin
    acc = crc_i ^ data_i;
    for (int i = 0; i < 32; i++) begin
      acc = acc[0] ? ((acc >> 1) ^ POLY) : (acc >> 1);
    end
    crc_o = acc;
  end
endmodule

module crc32_frame_ctrl #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             s_valid_i,
  output logic             s_ready_o,
  input  logic [31:0]      s_data_i,
  input  logic [3:0]       s_keep_i,
  input  logic             s_last_i,
  output logic             crc_valid_o,
  input  logic             crc_ready_i,
  output logic [31:0]      crc_o,
  output logic             crc_ok_o,
  output logic [LEN_W-1:0] byte_cnt_o
);
  localparam logic [31:0] POLY    = 32'hEDB88320;
  localparam logic [31:0] SEED    = 32'hFFFFFFFF;
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

  typedef enum logic [1:0] {IDLE, RUN, TAIL, DONE} state_t;

  state_t           state_q, state_d;
  logic [31:0]      crc_q, crc_d;
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [31:0]      tail_q, tail_d;
  logic [1:0]       rem_q, rem_d;
  logic [31:0]      res_crc_q, res_crc_d;
  logic             res_ok_q, res_ok_d;
  logic [LEN_W-1:0] res_cnt_q, res_cnt_d;

  logic [31:0]      core_out;
  logic [2:0]       tail_n;
  logic             xfer;

  // Single shared word core; the tail path uses byte_step below instead.
  crc32_word_core u_core (
    .crc_i  (crc_q),
    .data_i (s_data_i),
    .crc_o  (core_out)
  );

  // One byte folded into the low end of the register, LSB first.
  function automatic logic [31:0] byte_step(input logic [31:0] c_in, input logic [7:0] b);
    logic [31:0] c;
    c = c_in ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ POLY) : (c >> 1);
    end
    return c;
  endfunction

  // Counter add that sticks at all-ones instead of wrapping.
  function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a, input logic [2:0] inc);
    logic [LEN_W:0] sum;
    sum = {1'b0, a} + {{(LEN_W-2){1'b0}}, inc};
    return sum[LEN_W] ? {LEN_W{1'b1}} : sum[LEN_W-1:0];
  endfunction

  // Ready is gated by reset so it is low during the reset cycle itself.
  assign s_ready_o   = !rst_i && ((state_q == IDLE) || (state_q == RUN));
  assign xfer        = s_valid_i && s_ready_o;
  assign crc_valid_o = (state_q == DONE);
  assign crc_o       = res_crc_q;
  assign crc_ok_o    = res_ok_q;
  assign byte_cnt_o  = res_cnt_q;

  // Tail length from the highest set keep bit; lower bits are assumed contiguous.
  always_comb begin
    tail_n = 3'd0;
    if (s_keep_i[3])      tail_n = 3'd4;
    else if (s_keep_i[2]) tail_n = 3'd3;
    else if (s_keep_i[1]) tail_n = 3'd2;
    else if (s_keep_i[0]) tail_n = 3'd1;
  end

  // Next-state, CRC/count update and result capture on entry to DONE.
  always_comb begin
    state_d   = state_q;
    crc_d     = crc_q;
    cnt_d     = cnt_q;
    tail_d    = tail_q;
    rem_d     = rem_q;
    res_crc_d = res_crc_q;
    res_ok_d  = res_ok_q;
    res_cnt_d = res_cnt_q;

    case (state_q)
      IDLE, RUN: begin
        if (xfer) begin
          if (!s_last_i) begin
            crc_d   = core_out;
            cnt_d   = sat_add(cnt_q, 3'd4);
            state_d = RUN;
          end else if (tail_n == 3'd4) begin
            crc_d   = core_out;
            cnt_d   = sat_add(cnt_q, 3'd4);
            state_d = DONE;
          end else if (tail_n == 3'd0) begin
            state_d = DONE;
          end else begin
            tail_d  = s_data_i;
            rem_d   = tail_n[1:0];
            cnt_d   = sat_add(cnt_q, tail_n);
            state_d = TAIL;
          end
        end
      end
      TAIL: begin
        crc_d  = byte_step(crc_q, tail_q[7:0]);
        tail_d = tail_q >> 8;
        rem_d  = rem_q - 2'd1;
        if (rem_q == 2'd1) state_d = DONE;
      end
      DONE: begin
        if (crc_ready_i) begin
          state_d = IDLE;
          crc_d   = SEED;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    if ((state_d == DONE) && (state_q != DONE)) begin
      res_crc_d = ~crc_d;
      res_ok_d  = (crc_d == RESIDUE);
      res_cnt_d = cnt_d;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      crc_q     <= SEED;
      cnt_q     <= '0;
      tail_q    <= '0;
      rem_q     <= '0;
      res_crc_q <= '0;
      res_ok_q  <= 1'b0;
      res_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      crc_q     <= crc_d;
      cnt_q     <= cnt_d;
      tail_q    <= tail_d;
      rem_q     <= rem_d;
      res_crc_q <= res_crc_d;
      res_ok_q  <= res_ok_d;
      res_cnt_q <= res_cnt_d;
    end
  end
endmodule

// File: tb/tb_crc32_frame_ctrl.sv
// Directed bench for crc32_frame_ctrl: known CRC vectors, latency, stalls, reset, saturation.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Result backpressure exercised explicitly via crc_ready_i.
module tb_crc32_frame_ctrl;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        s_valid_i;
  logic        s_ready_o;
  logic [31:0] s_data_i;
  logic [3:0]  s_keep_i;
  logic        s_last_i;
  logic        crc_valid_o;
  logic        crc_ready_i;
  logic [31:0] crc_o;
  logic        crc_ok_o;
  logic [15:0] byte_cnt_o;

  int checks = 0;
  int errors = 0;

  crc32_frame_ctrl #(.LEN_W(16)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .s_valid_i   (s_valid_i),
    .s_ready_o   (s_ready_o),
    .s_data_i    (s_data_i),
    .s_keep_i    (s_keep_i),
    .s_last_i    (s_last_i),
    .crc_valid_o (crc_valid_o),
    .crc_ready_i (crc_ready_i),
    .crc_o       (crc_o),
    .crc_ok_o    (crc_ok_o),
    .byte_cnt_o  (byte_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  // Present one word and hold it until accepted (bounded wait).
  task automatic send_word(input logic [31:0] d, input logic [3:0] k, input logic l);
    int guard;
    guard     = 0;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_keep_i  = k;
    s_last_i  = l;
    @(negedge clk_i);
    while (s_ready_o !== 1'b1 && guard < 50) begin
      @(negedge clk_i);
      guard++;
    end
    if (guard >= 50) begin
      checks++;
      errors++;
      $display("FAIL send_timeout ready=%b required=1", s_ready_o);
    end
    @(posedge clk_i);
    #1;
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
    s_keep_i  = 4'h0;
    s_data_i  = 32'h0;
  endtask

  // Idle the input for g cycles.
  task automatic gap(input int g);
    repeat (g) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  // Wait for a result after the last-word transfer; lat counts cycles (0 = timed out).
  task automatic get_result(input bit consume, output int lat, output logic [31:0] c,
                            output logic ok, output logic [15:0] n);
    lat = 0;
    c   = 32'h0;
    ok  = 1'b0;
    n   = 16'h0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk_i);
      if (crc_valid_o === 1'b1) begin
        lat = i;
        break;
      end
    end
    c  = crc_o;
    ok = crc_ok_o;
    n  = byte_cnt_o;
    if (lat != 0 && consume) begin
      crc_ready_i = 1'b1;
      @(posedge clk_i);
      #1;
      crc_ready_i = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (s_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got=%b want=0", s_ready_o); end
    checks++; if (crc_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", crc_valid_o); end
    checks++; if (crc_o !== 32'h0) begin errors++; $display("FAIL rst_crc got=%h want=0", crc_o); end
    checks++; if (crc_ok_o !== 1'b0) begin errors++; $display("FAIL rst_ok got=%b want=0", crc_ok_o); end
    checks++; if (byte_cnt_o !== 16'h0) begin errors++; $display("FAIL rst_cnt got=%h want=0", byte_cnt_o); end
    rst_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got=%b want=1", s_ready_o); end
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_check_value();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    send_word(32'h34333231, 4'hF, 1'b0);
    send_word(32'h38373635, 4'hF, 1'b0);
    send_word(32'h00000039, 4'h1, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (lat != 2) begin errors++; $display("FAIL t1_lat got=%0d want=2", lat); end
    checks++; if (c !== 32'hCBF43926) begin errors++; $display("FAIL t1_crc got=%h want=cbf43926", c); end
    checks++; if (n !== 16'd9) begin errors++; $display("FAIL t1_cnt got=%0d want=9", n); end
    checks++; if (ok !== 1'b0) begin errors++; $display("FAIL t1_ok got=%b want=0", ok); end
  endtask

  task automatic test_single();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    send_word(32'h00000000, 4'hF, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (lat != 1) begin errors++; $display("FAIL t2a_lat got=%0d want=1", lat); end
    checks++; if (c !== 32'h2144DF1C) begin errors++; $display("FAIL t2a_crc got=%h want=2144df1c", c); end
    checks++; if (n !== 16'd4) begin errors++; $display("FAIL t2a_cnt got=%0d want=4", n); end
    send_word(32'h00000000, 4'h1, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (lat != 2) begin errors++; $display("FAIL t2b_lat got=%0d want=2", lat); end
    checks++; if (c !== 32'hD202EF8D) begin errors++; $display("FAIL t2b_crc got=%h want=d202ef8d", c); end
    checks++; if (n !== 16'd1) begin errors++; $display("FAIL t2b_cnt got=%0d want=1", n); end
  endtask

  task automatic test_residue();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    send_word(32'h34333231, 4'hF, 1'b0);
    send_word(32'h38373635, 4'hF, 1'b0);
    send_word(32'hF4392639, 4'hF, 1'b0);
    send_word(32'h000000CB, 4'h1, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t3_ok got=%b want=1", ok); end
    checks++; if (c !== 32'h2144DF1C) begin errors++; $display("FAIL t3_crc got=%h want=2144df1c", c); end
    checks++; if (n !== 16'd13) begin errors++; $display("FAIL t3_cnt got=%0d want=13", n); end
  endtask

  task automatic test_backpressure();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    int bad;
    send_word(32'h00000000, 4'hF, 1'b1);
    get_result(1'b0, lat, c, ok, n);
    checks++; if (lat != 1) begin errors++; $display("FAIL t4_lat got=%0d want=1", lat); end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      if (crc_valid_o !== 1'b1 || s_ready_o !== 1'b0 || crc_o !== 32'h2144DF1C || byte_cnt_o !== 16'd4)
        bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL t4_hold bad_cycles=%0d want=0", bad); end
    crc_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    crc_ready_i = 1'b0;
    @(negedge clk_i);
    checks++; if (s_ready_o !== 1'b1) begin errors++; $display("FAIL t4_ready_after got=%b want=1", s_ready_o); end
    checks++; if (crc_valid_o !== 1'b0) begin errors++; $display("FAIL t4_valid_after got=%b want=0", crc_valid_o); end
    // Same "123456789" frame with idle gaps between words.
    gap($urandom_range(0, 3));
    send_word(32'h34333231, 4'hF, 1'b0);
    gap($urandom_range(1, 4));
    send_word(32'h38373635, 4'hF, 1'b0);
    gap($urandom_range(1, 4));
    send_word(32'h00000039, 4'h1, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (c !== 32'hCBF43926) begin errors++; $display("FAIL t4_gap_crc got=%h want=cbf43926", c); end
    checks++; if (n !== 16'd9) begin errors++; $display("FAIL t4_gap_cnt got=%0d want=9", n); end
  endtask

  task automatic test_reset_midframe();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    int seen;
    send_word(32'h34333231, 4'hF, 1'b0);
    send_word(32'h38373635, 4'hF, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      if (crc_valid_o !== 1'b0) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL t5_no_result valid_cycles=%0d want=0", seen); end
    @(posedge clk_i);
    #1;
    send_word(32'h00000000, 4'hF, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (c !== 32'h2144DF1C) begin errors++; $display("FAIL t5_crc got=%h want=2144df1c", c); end
    checks++; if (n !== 16'd4) begin errors++; $display("FAIL t5_cnt got=%0d want=4", n); end
  endtask

  task automatic test_keep_zero();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    send_word(32'h34333231, 4'hF, 1'b0);
    send_word(32'hDEADBEEF, 4'h0, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (lat != 1) begin errors++; $display("FAIL t6_lat got=%0d want=1", lat); end
    checks++; if (c !== 32'h9BE3E0A3) begin errors++; $display("FAIL t6_crc got=%h want=9be3e0a3", c); end
    checks++; if (n !== 16'd4) begin errors++; $display("FAIL t6_cnt got=%0d want=4", n); end
  endtask

  task automatic test_saturate();
    int lat; logic [31:0] c; logic ok; logic [15:0] n;
    for (int i = 0; i < 16384; i++) send_word(32'h00000000, 4'hF, 1'b0);
    send_word(32'h00000000, 4'hF, 1'b1);
    get_result(1'b1, lat, c, ok, n);
    checks++; if (lat != 1) begin errors++; $display("FAIL t7_lat got=%0d want=1", lat); end
    checks++; if (n !== 16'hFFFF) begin errors++; $display("FAIL t7_cnt got=%h want=ffff", n); end
  endtask

  initial begin
    rst_i       = 1'b1;
    s_valid_i   = 1'b0;
    s_data_i    = 32'h0;
    s_keep_i    = 4'h0;
    s_last_i    = 1'b0;
    crc_ready_i = 1'b0;
    test_reset();
    test_check_value();
    test_single();
    test_residue();
    test_backpressure();
    test_reset_midframe();
    test_keep_zero();
    test_saturate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
